spi_master_ctrl: RTL

//  Upstream SPI master that drives the SPI-slave + single-port-RAM wrapper (SS_n/MOSI/MISO).
//  - Accepts one 10-bit command word {cmd[9:8], payload[7:0]} per valid/ready handshake.
//  - Serialises the word onto MOSI at system-clock rate.
//  - For READ_DATA (cmd=2'b11), waits for and captures the 8-bit MISO reply and presents it on rd_data.
//  - Cmd codes: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.

---
 rtl/spi_master_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master that serialises {cmd[1:0], payload[7:0]} frames MSB first onto MOSI and captures MISO read replies.
// Latency: SS_n falls the cycle after accept; an RD_DATA reply appears on rd_data/rd_valid in the first GAP cycle.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is ignored and must be held by the source.
// Optional build macro SPI_MASTER_STATS_EN adds frame_cnt/rd_cnt statistics outputs.
module spi_master_ctrl #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [FRAME_W-1:0] cmd_data,
  output logic               cmd_ready,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy
`ifdef SPI_MASTER_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        rd_cnt
`endif
);

  // One shared cycle counter covers every multi-cycle state; it restarts at 0 on each state entry.
  localparam int MAX_A   = (FRAME_W > DATA_W) ? FRAME_W : DATA_W;
  localparam int MAX_B   = (RD_WAIT > GAP) ? RD_WAIT : GAP;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [DATA_W-2:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               is_rd_q, is_rd_d;
  logic [DATA_W-1:0]  rx_full;

  // The byte completed by the current MISO sample: earlier bits plus the bit on the wire now.
  assign rx_full = {rx_q, MISO};

  // Moore outputs decoded from the state register; cmd_ready is also blocked while rst is high.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !rst;
    busy      = (state_q != S_IDLE);
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    case (state_q)
      S_SEL, S_SHIFT: begin
        SS_n = 1'b0;
        MOSI = shift_q[FRAME_W-1];
      end
      S_WAIT, S_RECV: begin
        SS_n = 1'b0;
      end
      default: begin
        SS_n = 1'b1;
      end
    endcase
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // Next-state logic: walks the frame, shifts MOSI out in SHIFT and MISO in during RECV.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    is_rd_d    = is_rd_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = S_SEL;
          cnt_d   = '0;
          shift_d = cmd_data;
          // Read-vs-not is latched now because the shift register loses the command bits.
          is_rd_d = (cmd_data[FRAME_W-1 -: 2] == 2'b11);
        end
      end
      S_SEL: begin
        // SEL repeats the MSB so the slave sees its select bit before the frame; no shift here.
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (is_rd_q) begin
            state_d = (RD_WAIT > 0) ? S_WAIT : S_RECV;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RECV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RECV: begin
        rx_d = rx_full[DATA_W-2:0];
        if (cnt_q == RECV_LAST) begin
          // rd_data only changes when a read reply completes, so it holds across other frames.
          state_d    = S_GAP;
          cnt_d      = '0;
          rd_data_d  = rx_full;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame without a reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      is_rd_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      is_rd_q    <= is_rd_d;
    end
  end

`ifdef SPI_MASTER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] rd_cnt_q;

  // Statistics: completed frames counted on GAP entry, replies counted with each rd_valid; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      rd_cnt_q    <= '0;
    end else begin
      if ((state_d == S_GAP) && (state_q != S_GAP)) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (rd_valid_d) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign rd_cnt    = rd_cnt_q;
`endif

endmodule
